clock_divider_controller: RTL and testbench

CLOCK_DIVIDER_CONTROLLER -- requirements
Module: clock_divider_controller

---
 rtl/clock_divider_controller_pkg.sv | 19 +
 rtl/clock_divider_controller_tick_counter.sv | 40 ++++
 rtl/clock_divider_controller.sv | 109 ++++++++++
 tb/tb_clock_divider_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_divider_controller_pkg.sv
// Shared definitions for the clock divider controller: FSM encoding and the
// smallest divisor the controller will accept.
package clock_divider_controller_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_PENDING  = 2'd2;
    localparam logic [1:0] ST_STOPPING = 2'd3;

    localparam int MIN_DIVIDER = 2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        RUN      = ST_RUN,
        PENDING  = ST_PENDING,
        STOPPING = ST_STOPPING
    } state_t;

endpackage

// File: rtl/clock_divider_controller_tick_counter.sv
// Period counter for the clock divider: counts 0..divisor-1 and raises a
// registered tick on the last count of each period.
module divider_tick_counter #(
    parameter int bitsNumber = 8
) (
    input  logic                  inputCLK,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  countEnable,
    input  logic [bitsNumber-1:0] divisor,
    output logic [bitsNumber-1:0] count,
    output logic                  tick
);

    logic [bitsNumber-1:0] count_next;
    logic                  wrap;

    always_comb begin
        wrap       = (count == divisor - 1'b1);
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (countEnable) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    // tick is looked ahead one cycle so it stays a flop; any divisor change
    // lands when count_next is 0, which can never equal divisor-1.
    always_ff @(posedge inputCLK) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            count <= count_next;
            tick  <= countEnable & ~clear & (count_next == divisor - 1'b1);
        end
    end

endmodule

// File: rtl/clock_divider_controller.sv
// Clock divider controller: runs a period counter on request and swaps the
// divisor either immediately (idle) or on a period boundary (running).
module clock_divider_controller
    import clock_divider_controller_pkg::*;
#(
    parameter int bitsNumber     = 8,
    parameter int defaultDivider = 2
) (
    input  logic                  inputCLK,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  cfgValid,
    input  logic [bitsNumber-1:0] cfgDivider,
    output logic                  cfgReady,
    output logic                  tick,
    output logic                  running,
    output logic                  cfgApplied,
    output logic                  cfgError
);

    // Config handshake: a divisor transfers on any rising edge where cfgValid
    // and cfgReady are both 1; cfgValid while cfgReady is 0 is dropped.
    state_t                state;
    logic [bitsNumber-1:0] divisor;
    logic [bitsNumber-1:0] pending;
    logic [bitsNumber-1:0] count;
    logic                  accept;
    logic                  legal;
    logic                  take;
    logic                  period_end;
    logic                  clear;

    assign accept     = cfgValid & cfgReady;
    assign legal      = cfgDivider >= bitsNumber'(MIN_DIVIDER);
    assign take       = accept & legal;
    assign period_end = running & (count == divisor - 1'b1);
    assign clear      = period_end & ~enable & ~take;

    divider_tick_counter #(
        .bitsNumber(bitsNumber)
    ) u_counter (
        .inputCLK   (inputCLK),
        .reset      (reset),
        .clear      (clear),
        .countEnable(running),
        .divisor    (divisor),
        .count      (count),
        .tick       (tick)
    );

    always_ff @(posedge inputCLK) begin
        if (!reset) begin
            state      <= IDLE;
            divisor    <= bitsNumber'(defaultDivider);
            pending    <= '0;
            running    <= 1'b0;
            cfgReady   <= 1'b0;
            cfgApplied <= 1'b0;
            cfgError   <= 1'b0;
        end else begin
            cfgApplied <= 1'b0;
            cfgError   <= accept & ~legal;
            cfgReady   <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        divisor    <= cfgDivider;
                        cfgApplied <= 1'b1;
                    end
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                // RUN and STOPPING differ only in which way enable last moved;
                // the period always finishes before the counter halts.
                RUN, STOPPING: begin
                    if (take) begin
                        pending  <= cfgDivider;
                        state    <= PENDING;
                        cfgReady <= 1'b0;
                    end else if (enable) begin
                        state <= RUN;
                    end else if (period_end) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        state <= STOPPING;
                    end
                end
                PENDING: begin
                    cfgReady <= period_end;
                    if (period_end) begin
                        divisor    <= pending;
                        cfgApplied <= 1'b1;
                        if (enable) begin
                            state <= RUN;
                        end else begin
                            state   <= IDLE;
                            running <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_divider_controller.sv
// Bench for clock_divider_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_clock_divider_controller;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       cfg_valid;
    logic [3:0] cfg_div;
    logic       cfg_ready;
    logic       tick;
    logic       running;
    logic       cfg_applied;
    logic       cfg_error;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: an active flag, a position within the period, the
    // divisor in force and a waiting divisor (0 means none waiting).
    bit  m_active;
    int  m_cnt;
    int  m_div;
    int  m_pend;
    bit  m_ready;
    bit  m_app;
    bit  m_err;
    logic [4:0] exp_q[$];

    clock_divider_controller #(
        .bitsNumber    (4),
        .defaultDivider(2)
    ) dut (
        .inputCLK  (clk),
        .reset     (rst_n),
        .enable    (en),
        .cfgValid  (cfg_valid),
        .cfgDivider(cfg_div),
        .cfgReady  (cfg_ready),
        .tick      (tick),
        .running   (running),
        .cfgApplied(cfg_applied),
        .cfgError  (cfg_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        bit acc, ok, tk;
        if (!rst_n) begin
            m_active = 0; m_cnt = 0; m_div = 2; m_pend = 0;
            m_ready = 0; m_app = 0; m_err = 0;
        end else begin
            acc   = cfg_valid && m_ready;
            ok    = acc && (cfg_div >= 2);
            tk    = m_active && (m_cnt == m_div - 1);
            m_err = acc && !ok;
            m_app = 0;
            if (!m_active) begin
                if (ok) begin
                    m_div = cfg_div;
                    m_app = 1;
                end
                if (en) begin
                    m_active = 1;
                    m_cnt    = 0;
                end
            end else begin
                m_cnt = tk ? 0 : m_cnt + 1;
                if (m_pend != 0) begin
                    if (tk) begin
                        m_div  = m_pend;
                        m_pend = 0;
                        m_app  = 1;
                        if (!en) m_active = 0;
                    end
                end else if (ok) begin
                    m_pend = cfg_div;
                end else if (tk && !en) begin
                    m_active = 0;
                end
            end
            m_ready = (m_pend == 0);
        end
        exp_q.push_back({m_active && (m_cnt == m_div - 1), m_active, m_ready, m_app, m_err});
    end

    always @(negedge clk) begin : compare
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tick", tick, e[4]);
            chk("running", running, e[3]);
            chk("cfgReady", cfg_ready, e[2]);
            chk("cfgApplied", cfg_applied, e[1]);
            chk("cfgError", cfg_error, e[0]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; en = 0; cfg_valid = 0; cfg_div = '0;
        cyc();
        chk("rst_tick", tick, 1'b0);
        chk("rst_running", running, 1'b0);
        chk("rst_ready", cfg_ready, 1'b0);
        chk("rst_applied", cfg_applied, 1'b0);
        chk("rst_error", cfg_error, 1'b0);
        cyc();
        rst_n = 1;
        cyc();
        chk("post_rst_ready", cfg_ready, 1'b1);
    endtask

    task automatic write_cfg(input logic [3:0] d);
        cfg_valid = 1; cfg_div = d;
        cyc();
        cfg_valid = 0;
    endtask

    initial begin
        rst_n = 0; en = 0; cfg_valid = 0; cfg_div = '0;

        // default divisor 2: ticks 2,4,6 cycles after enable
        do_reset();
        en = 1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("d2_running", running, 1'b1);
            chk("d2_tick", tick, (i == 2 || i == 4 || i == 6));
        end

        // idle write of 5, then switch to 3 mid-period, then illegal writes
        do_reset();
        write_cfg(4'd5);
        chk("idle_applied", cfg_applied, 1'b1);
        chk("idle_running", running, 1'b0);
        en = 1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("d5_tick", tick, (i == 5 || i == 10));
        end
        write_cfg(4'd3);
        chk("pend_ready", cfg_ready, 1'b0);
        chk("pend_applied", cfg_applied, 1'b0);
        for (int i = 14; i <= 21; i++) begin
            cyc();
            chk("sw_tick", tick, (i == 15 || i == 18 || i == 21));
            chk("sw_applied", cfg_applied, (i == 16));
            if (i >= 16) chk("sw_ready", cfg_ready, 1'b1);
        end
        write_cfg(4'd1);
        chk("err1", cfg_error, 1'b1);
        write_cfg(4'd0);
        chk("err0", cfg_error, 1'b1);
        for (int i = 24; i <= 27; i++) begin
            cyc();
            chk("err_tick", tick, (i == 24 || i == 27));
            chk("err_clear", cfg_error, 1'b0);
        end

        // divisor 4: stop mid-period, then a one-cycle enable glitch
        do_reset();
        write_cfg(4'd4);
        en = 1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            chk("d4_tick", tick, (i == 4));
        end
        en = 0;
        for (int i = 7; i <= 9; i++) begin
            cyc();
            chk("stop_tick", tick, (i == 8));
            chk("stop_running", running, (i != 9));
        end
        en = 1;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk("re_tick", tick, (j == 4));
        end
        en = 0;
        cyc();
        en = 1;
        for (int j = 7; j <= 12; j++) begin
            cyc();
            chk("glitch_tick", tick, (j == 8 || j == 12));
            chk("glitch_running", running, 1'b1);
        end

        // reset while a divisor is pending
        do_reset();
        write_cfg(4'd5);
        en = 1;
        cyc();
        cyc();
        write_cfg(4'd3);
        chk("pr_pend_ready", cfg_ready, 1'b0);
        rst_n = 0;
        cyc();
        chk("pr_tick", tick, 1'b0);
        chk("pr_running", running, 1'b0);
        chk("pr_ready", cfg_ready, 1'b0);
        chk("pr_applied", cfg_applied, 1'b0);
        chk("pr_error", cfg_error, 1'b0);
        rst_n = 1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("pr_after_ready", cfg_ready, 1'b1);
            chk("pr_after_tick", tick, (i == 2 || i == 4));
        end

        // randomized traffic, model comparison only
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) en = ~en;
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = 4'($urandom_range(0, 15));
            rst_n     = ($urandom_range(0, 299) != 0);
            cyc();
        end
        rst_n = 1; cfg_valid = 0; en = 0;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
